prog_loader: RTL and testbench

Byte-to-word loader that sits directly downstream of the UART receive path in the boot flow. It takes the received byte stream (valid strobe plus 8-bit data) and assembles little-endian 32-bit words. It writes those words to instruction memory during the program segment and to data memory during the data segment. A segment-end pulse from the UART sequencer closes each segment, flushing any partial word. The block raises `load_done` once both segments are loaded, which releases the core.

---
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time loader: packs received UART bytes into little-endian 32-bit words and
// writes them to instruction memory (program segment), then data memory (data segment).
module prog_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned PROG_BASE = 0,
  parameter int unsigned DATA_BASE = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              seg_end,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_done,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_PROG   = 3'd0,
    S_PFLUSH = 3'd1,
    S_DATA   = 3'd2,
    S_DFLUSH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX    = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PROG_START = PROG_BASE[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] DATA_START = DATA_BASE[ADDR_W-1:0];

  state_t              state_r, state_nxt_s;
  logic [1:0]          bc_r, bc_nxt_s;
  logic [31:0]         buf_r, word_s;
  logic [ADDR_W-1:0]   ptr_r;
  logic                sat_r;
  logic                in_seg_s, accept_s, flush_s, write_s, enter_data_s;

  // Byte assembly, flush decision and next-state selection.
  always_comb begin
    state_nxt_s  = state_r;
    word_s       = buf_r;
    in_seg_s     = (state_r == S_PROG) || (state_r == S_DATA);
    accept_s     = in_seg_s && byte_valid;
    // Starting a fresh word clears the upper lanes, so a flushed word comes out zero-padded.
    if (accept_s) begin
      case (bc_r)
        2'd0:    word_s = {24'h000000, byte_data};
        2'd1:    word_s = {16'h0000, byte_data, buf_r[7:0]};
        2'd2:    word_s = {8'h00, byte_data, buf_r[15:0]};
        default: word_s = {byte_data, buf_r[23:0]};
      endcase
    end else begin
      word_s = buf_r;
    end
    bc_nxt_s = accept_s ? (bc_r + 2'd1) : bc_r;
    flush_s  = in_seg_s && seg_end && (bc_nxt_s != 2'd0);
    write_s  = (accept_s && (bc_r == 2'd3)) || flush_s;
    case (state_r)
      S_PROG: begin
        if (seg_end) begin
          state_nxt_s = flush_s ? S_PFLUSH : S_DATA;
        end else begin
          state_nxt_s = S_PROG;
        end
      end
      S_PFLUSH: state_nxt_s = S_DATA;
      S_DATA: begin
        if (seg_end) begin
          state_nxt_s = flush_s ? S_DFLUSH : S_DONE;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_DFLUSH: state_nxt_s = S_DONE;
      S_DONE:   state_nxt_s = S_DONE;
      default:  state_nxt_s = S_PROG;
    endcase
    enter_data_s = (state_nxt_s == S_DATA) && (state_r != S_DATA);
  end

  // State, assembly registers, write pointer and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= S_PROG;
      bc_r      <= 2'd0;
      buf_r     <= 32'h0000_0000;
      ptr_r     <= PROG_START;
      sat_r     <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= PROG_START;
      mem_wdata <= 32'h0000_0000;
      load_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      mem_we  <= write_s && !sat_r;
      if (write_s && !sat_r) begin
        mem_addr  <= ptr_r;
        mem_wdata <= word_s;
        if (ptr_r == PTR_MAX) begin
          overflow <= 1'b1;
        end
      end
      if (enter_data_s) begin
        ptr_r <= DATA_START;
        sat_r <= 1'b0;
        bc_r  <= 2'd0;
        buf_r <= 32'h0000_0000;
      end else begin
        bc_r  <= flush_s ? 2'd0 : bc_nxt_s;
        buf_r <= word_s;
        if (write_s && !sat_r) begin
          if (ptr_r == PTR_MAX) begin
            sat_r <= 1'b1;
          end else begin
            ptr_r <= ptr_r + PTR_ONE;
          end
        end
      end
      // Lags the state by one cycle so a last old-segment write still carries the old select.
      mem_sel   <= (state_r == S_DATA) || (state_r == S_DFLUSH) || (state_r == S_DONE);
      load_done <= load_done || (state_nxt_s == S_DONE);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default-size instance plus a 2-bit-address
// instance for pointer saturation, both fed from the same byte stream.
module tb_prog_loader;

  logic        CLK;
  logic        RST_N;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        seg_end;

  logic        we_a, sel_a, done_a, ovf_a;
  logic [11:0] addr_a;
  logic [31:0] wdata_a;
  logic        we_b, sel_b, done_b, ovf_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;

  int n_chk  = 0;
  int n_pass = 0;
  int we_cnt_a = 0;
  int we_cnt_b = 0;
  int snap;

  prog_loader #(.ADDR_W(12), .PROG_BASE(0), .DATA_BASE(0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .byte_valid(byte_valid), .byte_data(byte_data),
    .seg_end(seg_end), .mem_we(we_a), .mem_sel(sel_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .load_done(done_a), .overflow(ovf_a)
  );

  prog_loader #(.ADDR_W(2), .PROG_BASE(0), .DATA_BASE(0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .byte_valid(byte_valid), .byte_data(byte_data),
    .seg_end(seg_end), .mem_we(we_b), .mem_sel(sel_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .load_done(done_b), .overflow(ovf_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write-pulse counters, sampled on the falling edge.
  always @(negedge CLK) begin
    if (we_a) we_cnt_a <= we_cnt_a + 1;
    if (we_b) we_cnt_b <= we_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the sampling edge.
  task automatic send(input logic v, input logic [7:0] b, input logic se);
    byte_valid = v;
    byte_data  = b;
    seg_end    = se;
    @(posedge CLK);
    #1;
    byte_valid = 1'b0;
    seg_end    = 1'b0;
  endtask

  task automatic pulse_reset();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
  endtask

  logic [7:0] prog_bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [31:0] prog_words [2] = '{32'h0000_0013, 32'h0010_0093};
  logic [7:0] b0;

  initial begin
    RST_N = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; seg_end = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    check("rst_we",    {31'd0, we_a},   32'd0);
    check("rst_sel",   {31'd0, sel_a},  32'd0);
    check("rst_addr",  {20'd0, addr_a}, 32'd0);
    check("rst_wdata", wdata_a,         32'd0);
    check("rst_done",  {31'd0, done_a}, 32'd0);
    check("rst_ovf",   {31'd0, ovf_a},  32'd0);

    // Program words, then a reset in the middle of a third word.
    for (int i = 0; i < 8; i++) begin
      send(1'b1, prog_bytes[i], 1'b0);
      if (i % 4 == 3) begin
        check("prog_we",    {31'd0, we_a},   32'd1);
        check("prog_addr",  {20'd0, addr_a}, i / 4);
        check("prog_wdata", wdata_a,         prog_words[i / 4]);
        check("prog_sel",   {31'd0, sel_a},  32'd0);
      end else if (i == 4) begin
        check("we_single", {31'd0, we_a}, 32'd0);
      end
    end
    send(1'b1, 8'h55, 1'b0);
    send(1'b1, 8'h66, 1'b0);
    RST_N = 1'b0;
    #2;
    check("midrst_addr",  {20'd0, addr_a}, 32'd0);
    check("midrst_wdata", wdata_a,         32'd0);
    check("midrst_we",    {31'd0, we_a},   32'd0);
    RST_N = 1'b1;
    send(1'b1, 8'h44, 1'b0);
    send(1'b1, 8'h33, 1'b0);
    send(1'b1, 8'h22, 1'b0);
    check("postrst_early", {31'd0, we_a}, 32'd0);
    send(1'b1, 8'h11, 1'b0);
    check("postrst_we",    {31'd0, we_a},   32'd1);
    check("postrst_addr",  {20'd0, addr_a}, 32'd0);
    check("postrst_wdata", wdata_a,         32'h1122_3344);

    // Full boot: program, empty-tail seg_end, data with coincident seg_end flush.
    pulse_reset();
    for (int i = 0; i < 8; i++) send(1'b1, prog_bytes[i], 1'b0);
    check("boot_p1", wdata_a, 32'h0010_0093);
    snap = we_cnt_a;
    send(1'b0, 8'h00, 1'b1);
    check("pend_nowe", {31'd0, we_a}, 32'd0);
    send(1'b1, 8'hAA, 1'b0);
    send(1'b1, 8'hBB, 1'b0);
    send(1'b1, 8'hCC, 1'b0);
    send(1'b1, 8'hDD, 1'b0);
    check("d0_we",    {31'd0, we_a},   32'd1);
    check("d0_sel",   {31'd0, sel_a},  32'd1);
    check("d0_addr",  {20'd0, addr_a}, 32'd0);
    check("d0_wdata", wdata_a,         32'hDDCC_BBAA);
    send(1'b1, 8'h11, 1'b0);
    send(1'b1, 8'h22, 1'b1);
    check("d1_we",    {31'd0, we_a},   32'd1);
    check("d1_addr",  {20'd0, addr_a}, 32'd1);
    check("d1_wdata", wdata_a,         32'h0000_2211);
    check("d1_sel",   {31'd0, sel_a},  32'd1);
    check("done_t1",  {31'd0, done_a}, 32'd0);
    send(1'b0, 8'h00, 1'b0);
    check("done_t2",  {31'd0, done_a}, 32'd1);
    check("done_t2we", {31'd0, we_a},  32'd0);
    check("boot_wecnt", we_cnt_a - snap, 32'd3);

    // Everything in S_DONE is ignored.
    snap = we_cnt_a;
    for (int i = 0; i < 8; i++) send(1'b1, 8'hF0 + 8'(i), (i == 7) ? 1'b1 : 1'b0);
    send(1'b0, 8'h00, 1'b1);
    send(1'b0, 8'h00, 1'b0);
    check("sdone_nowe", we_cnt_a - snap, 32'd0);
    check("sdone_done", {31'd0, done_a}, 32'd1);

    // Empty segments: seg_end alone advances without writing.
    pulse_reset();
    snap = we_cnt_a;
    send(1'b0, 8'h00, 1'b1);
    check("empty_we",   {31'd0, we_a},   32'd0);
    check("empty_done", {31'd0, done_a}, 32'd0);
    send(1'b0, 8'h00, 1'b1);
    check("empty_done2", {31'd0, done_a}, 32'd1);
    check("empty_cnt",   we_cnt_a - snap, 32'd0);

    // 2-bit address instance: five full-rate words, only addresses 0..3 written.
    pulse_reset();
    snap = we_cnt_b;
    for (int w = 0; w < 5; w++) begin
      b0 = 8'hA0 + 8'(w);
      send(1'b1, b0, 1'b0);
      send(1'b1, 8'hC3, 1'b0);
      send(1'b1, 8'hB2, 1'b0);
      send(1'b1, 8'(w), 1'b0);
      if (w < 4) begin
        check("ovf_we",    {31'd0, we_b},   32'd1);
        check("ovf_addr",  {30'd0, addr_b}, w);
        check("ovf_wdata", wdata_b,         {8'(w), 8'hB2, 8'hC3, b0});
      end else begin
        check("ovf_5th_we", {31'd0, we_b}, 32'd0);
      end
      if (w == 2) check("ovf_early", {31'd0, ovf_b}, 32'd0);
    end
    send(1'b0, 8'h00, 1'b0);
    check("ovf_cnt",  we_cnt_b - snap, 32'd4);
    check("ovf_flag", {31'd0, ovf_b},  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
